// File: rtl/master_out_port_pkg.sv
// Shared bus definitions for the serial master/slave request link.
// Frame widths and the master serializer state encoding live here.
package master_out_port_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        SEND = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int BUS_ADDR_WIDTH = 12;
    localparam int BUS_DATA_WIDTH = 8;

endpackage

// File: rtl/piso_shift_reg.sv
// Parallel-in serial-out register; ser_out is bit 0, shift moves toward LSB and fills with 0.
// Load has priority over shift; no backpressure of its own, the owner gates shift.
module piso_shift_reg #(
    parameter int WIDTH = 12
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] par_in,
    output logic             ser_out
);

    logic [WIDTH-1:0] sr;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sr <= '0;
        end else if (load) begin
            sr <= par_in;
        end else if (shift) begin
            sr <= sr >> 1;
        end
    end

    assign ser_out = sr[0];

endmodule

// File: rtl/master_out_port.sv
// Serializes one address/data request LSB first; frame = 1 WAIT + ADDR_WIDTH SEND + 1 DONE cycle.
// slave_ready low holds the current bit and counter with master_valid high; start outside IDLE is dropped.
module master_out_port
    import master_out_port_pkg::*;
#(
    parameter int ADDR_WIDTH = BUS_ADDR_WIDTH,
    parameter int DATA_WIDTH = BUS_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  write_mode,
    input  logic [ADDR_WIDTH-1:0] addr_in,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  slave_ready,
    output logic                  master_valid,
    output logic                  tx_addr,
    output logic                  tx_data,
    output logic                  busy,
    output logic                  tx_done
);

    localparam int CNT_W = (ADDR_WIDTH > 1) ? $clog2(ADDR_WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(ADDR_WIDTH - 1);

    if (DATA_WIDTH > ADDR_WIDTH) begin : g_width_check
        $error("master_out_port: DATA_WIDTH must not exceed ADDR_WIDTH");
    end

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             load;
    logic             advance;
    logic             addr_bit;
    logic             data_bit;
    logic [ADDR_WIDTH-1:0] data_pad;

    // Read frames load a zero data lane so tx_data stays low without a mode check per bit.
    assign data_pad = write_mode ? ADDR_WIDTH'(data_in) : '0;
    assign load     = (state == IDLE) && start;
    assign advance  = slave_ready && ((state == WAIT) || ((state == SEND) && (cnt != LAST)));

    piso_shift_reg #(.WIDTH(ADDR_WIDTH)) u_addr_lane (
        .clk     (clk),
        .reset   (reset),
        .load    (load),
        .shift   (advance),
        .par_in  (addr_in),
        .ser_out (addr_bit)
    );

    piso_shift_reg #(.WIDTH(ADDR_WIDTH)) u_data_lane (
        .clk     (clk),
        .reset   (reset),
        .load    (load),
        .shift   (advance),
        .par_in  (data_pad),
        .ser_out (data_bit)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            cnt          <= '0;
            master_valid <= 1'b0;
            tx_addr      <= 1'b0;
            tx_data      <= 1'b0;
            busy         <= 1'b0;
            tx_done      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state        <= WAIT;
                        busy         <= 1'b1;
                        master_valid <= 1'b1;
                    end
                end
                WAIT: begin
                    if (slave_ready) begin
                        state   <= SEND;
                        cnt     <= '0;
                        tx_addr <= addr_bit;
                        tx_data <= data_bit;
                    end
                end
                SEND: begin
                    if (slave_ready) begin
                        if (cnt == LAST) begin
                            state        <= DONE;
                            master_valid <= 1'b0;
                            tx_addr      <= 1'b0;
                            tx_data      <= 1'b0;
                            tx_done      <= 1'b1;
                        end else begin
                            cnt     <= cnt + 1'b1;
                            tx_addr <= addr_bit;
                            tx_data <= data_bit;
                        end
                    end
                end
                DONE: begin
                    state   <= IDLE;
                    busy    <= 1'b0;
                    tx_done <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_master_out_port.sv
// Directed bench for master_out_port: write/read frames, stalls, ignored starts, held start, reset abort.
module tb_master_out_port;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        write_mode;
    logic [11:0] addr_in;
    logic [7:0]  data_in;
    logic        slave_ready;
    logic        master_valid;
    logic        tx_addr;
    logic        tx_data;
    logic        busy;
    logic        tx_done;

    int n_assert = 0;
    int n_fail   = 0;

    logic rec_mv [64];
    logic rec_ta [64];
    logic rec_td [64];
    logic rec_dn [64];
    logic rec_bz [64];
    int   mv_cnt, done_cnt, done_at, busy_cnt;
    logic [11:0] sa, sd;

    master_out_port dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .write_mode   (write_mode),
        .addr_in      (addr_in),
        .data_in      (data_in),
        .slave_ready  (slave_ready),
        .master_valid (master_valid),
        .tx_addr      (tx_addr),
        .tx_data      (tx_data),
        .busy         (busy),
        .tx_done      (tx_done)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Cycle 1 is the cycle right after the accepting edge; inputs set after recording cycle c apply at its closing edge.
    task automatic capture(input int n, input int stall_from, input int stall_to,
                           input int start_a, input int start_b, input logic hold,
                           input logic [11:0] addr_next);
        for (int c = 1; c <= n; c++) begin
            if (c > 1) step();
            rec_mv[c] = master_valid;
            rec_ta[c] = tx_addr;
            rec_td[c] = tx_data;
            rec_dn[c] = tx_done;
            rec_bz[c] = busy;
            slave_ready = !(c >= stall_from && c <= stall_to);
            start       = hold || (c == start_a) || (c == start_b);
            if (c == 1) addr_in = addr_next;
        end
        mv_cnt = 0; done_cnt = 0; done_at = 0; busy_cnt = 0;
        for (int c = 1; c <= n; c++) begin
            mv_cnt   += int'(rec_mv[c]);
            busy_cnt += int'(rec_bz[c]);
            if (rec_dn[c]) begin
                done_cnt++;
                if (done_at == 0) done_at = c;
            end
        end
    endtask

    task automatic gather(input int first);
        for (int k = 0; k < 12; k++) begin
            sa[k] = rec_ta[first + k];
            sd[k] = rec_td[first + k];
        end
    endtask

    task automatic drain();
        start = 1'b0;
        slave_ready = 1'b1;
        for (int i = 0; i < 20; i++) step();
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; write_mode = 1'b0;
        addr_in = 12'h000; data_in = 8'h00; slave_ready = 1'b1;

        // Reset state, including a start presented while held in reset
        step();
        check("reset_outputs", {master_valid, tx_addr, tx_data, busy, tx_done}, 5'b0);
        start = 1'b1; addr_in = 12'hFFF; data_in = 8'hFF; write_mode = 1'b1;
        step();
        check("reset_ignores_start", {master_valid, tx_addr, tx_data, busy, tx_done}, 5'b0);
        start = 1'b0; reset = 1'b1;
        step();

        // Write frame A5C / 3B
        addr_in = 12'hA5C; data_in = 8'h3B; write_mode = 1'b1; start = 1'b1;
        step();
        capture(16, 0, 0, 0, 0, 1'b0, 12'hA5C);
        gather(2);
        check("wr_wait_valid_busy", {rec_mv[1], rec_bz[1], rec_dn[1]}, 3'b110);
        check("wr_addr_seq", sa, 12'hA5C);
        check("wr_data_seq", sd, 12'h03B);
        check("wr_valid_cycles", mv_cnt, 13);
        check("wr_done_count", done_cnt, 1);
        check("wr_done_cycle", done_at, 14);
        check("wr_done_state", {rec_mv[14], rec_ta[14], rec_td[14], rec_bz[14]}, 4'b0001);
        check("wr_idle_after", {rec_bz[15], rec_mv[15]}, 2'b00);
        drain();

        // Read frame: data_in is nonzero but must not appear
        addr_in = 12'h001; data_in = 8'hFF; write_mode = 1'b0; start = 1'b1;
        step();
        capture(16, 0, 0, 0, 0, 1'b0, 12'h001);
        gather(2);
        check("rd_addr_seq", sa, 12'h001);
        check("rd_data_seq", sd, 12'h000);
        check("rd_done_count", done_cnt, 1);
        check("rd_done_cycle", done_at, 14);
        drain();

        // Stall 3 cycles while bit 4 is presented
        addr_in = 12'hA5C; data_in = 8'h3B; write_mode = 1'b1; start = 1'b1;
        step();
        capture(20, 6, 8, 0, 0, 1'b0, 12'hA5C);
        for (int k = 0; k < 4; k++) begin
            sa[k] = rec_ta[2 + k];
            sd[k] = rec_td[2 + k];
        end
        for (int k = 4; k < 12; k++) begin
            sa[k] = rec_ta[5 + k];
            sd[k] = rec_td[5 + k];
        end
        check("stall_addr_seq", sa, 12'hA5C);
        check("stall_data_seq", sd, 12'h03B);
        check("stall_addr_held", {rec_ta[6], rec_ta[7], rec_ta[8], rec_ta[9], rec_ta[10]}, 5'b11110);
        check("stall_data_held", {rec_td[6], rec_td[7], rec_td[8], rec_td[9]}, 4'b1111);
        check("stall_valid_cycles", mv_cnt, 16);
        check("stall_done_cycle", done_at, 17);
        drain();

        // slave_ready low for 5 cycles in WAIT
        addr_in = 12'h3C7; data_in = 8'h96; write_mode = 1'b1; start = 1'b1;
        step();
        capture(22, 1, 5, 0, 0, 1'b0, 12'h3C7);
        gather(7);
        check("wait_stall_addr_seq", sa, 12'h3C7);
        check("wait_stall_data_seq", sd, 12'h096);
        check("wait_stall_valid_cycles", mv_cnt, 18);
        check("wait_stall_done_cycle", done_at, 19);
        drain();

        // start pulses in SEND and in DONE are ignored
        addr_in = 12'h5A5; data_in = 8'h0F; write_mode = 1'b1; start = 1'b1;
        step();
        capture(22, 0, 0, 5, 14, 1'b0, 12'h5A5);
        check("ign_done_count", done_cnt, 1);
        check("ign_busy_cycles", busy_cnt, 14);
        check("ign_valid_cycles", mv_cnt, 13);
        drain();

        // start held high: a new frame every 15 cycles, second one takes the new address
        addr_in = 12'h123; data_in = 8'h45; write_mode = 1'b1; start = 1'b1;
        step();
        capture(30, 0, 0, 0, 0, 1'b1, 12'hDB6);
        check("hold_done_count", done_cnt, 2);
        check("hold_done_cycles", {rec_dn[14], rec_dn[29]}, 2'b11);
        check("hold_gap_busy", {rec_bz[15], rec_bz[16]}, 2'b01);
        gather(2);
        check("hold_frame1_addr", sa, 12'h123);
        gather(17);
        check("hold_frame2_addr", sa, 12'hDB6);
        check("hold_frame2_data", sd, 12'h045);
        drain();

        // Reset asserted while bit 5 is on the lanes
        addr_in = 12'hFFF; data_in = 8'hFF; write_mode = 1'b1; start = 1'b1;
        step();
        capture(7, 0, 0, 0, 0, 1'b0, 12'hFFF);
        check("pre_reset_mid_frame", {master_valid, tx_addr, tx_data, busy}, 4'b1111);
        #2 reset = 1'b0;
        #1;
        check("async_reset_outputs", {master_valid, tx_addr, tx_data, busy, tx_done}, 5'b0);
        step();
        reset = 1'b1;
        step();
        capture(20, 0, 0, 0, 0, 1'b0, 12'hFFF);
        check("abort_no_done", done_cnt, 0);
        check("abort_no_valid", mv_cnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/master_out_port.md
Name: master_out_port

Overview:
- Master-side serializer that drives the bit-serial request lines consumed by the slave input stage: address on tx_addr, write data on tx_data, framed by master_valid / slave_ready.
- Accepts one parallel request (address, data, read/write) from the master controller, shifts it out LSB first and pulses tx_done when the frame completes.
- Sits directly upstream of the slave port's rx_addr / rx_data / master_valid inputs.

Parameters:
- ADDR_WIDTH, 12, address bits per frame (BRAM address width). Sets the frame length.
- DATA_WIDTH, 8, data bits per frame. Must be <= ADDR_WIDTH; elaboration error otherwise.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  request strobe, sampled only in IDLE.
- write_mode  input  1  1 = write frame (data driven), 0 = read frame (tx_data held 0).
- addr_in  input  ADDR_WIDTH  request address, captured on accepted start.
- data_in  input  DATA_WIDTH  write data, captured on accepted start.
- slave_ready  input  1  slave can accept a bit this cycle.
- master_valid  output  1  frame in progress; bits on tx_addr/tx_data are meaningful.
- tx_addr  output  1  serial address bit.
- tx_data  output  1  serial data bit.
- busy  output  1  high in any state other than IDLE.
- tx_done  output  1  one-cycle pulse at frame completion.

Behaviour:
- Reset (reset=0, asynchronous): state IDLE; master_valid, tx_addr, tx_data, busy, tx_done all 0; shift registers and bit counter cleared. Reset mid-frame aborts the frame with no tx_done.
- All outputs registered; no combinational path from inputs to outputs.
- States: IDLE, WAIT, SEND, DONE.
- IDLE: on clk edge with start=1, capture addr_in, data_in, write_mode -> WAIT. The next cycle shows busy=1 and master_valid=1. start in any other state is ignored; it is not queued.
- WAIT: master_valid=1. On an edge with slave_ready=1 -> SEND; tx_addr <= addr[0], tx_data <= write ? data[0] : 0, counter <= 0. Waits indefinitely while slave_ready=0.
- SEND: master_valid=1. Bit k is presented while counter=k. A bit is transferred on each edge with master_valid=1 and slave_ready=1. On transfer, the counter increments and the next bit is presented.
  - slave_ready=0 stalls the frame: bit and counter hold, master_valid stays 1.
  - tx_data carries data[k] for k < DATA_WIDTH and 0 for k >= DATA_WIDTH. It is 0 for the whole frame in read mode.
  - On the transfer of bit ADDR_WIDTH-1 -> DONE; master_valid, tx_addr, tx_data <= 0.
- DONE: tx_done=1 for exactly one cycle, busy=1 -> IDLE. A start asserted during DONE is ignored; the earliest accepted start is the first cycle in IDLE.
- Minimum frame latency with slave_ready held 1: start edge, then 1 WAIT cycle, ADDR_WIDTH SEND cycles and 1 DONE cycle. The next start is accepted ADDR_WIDTH+3 cycles after the previous one.
- Counter width is clog2(ADDR_WIDTH). It never wraps within a frame and is cleared on entry to SEND.

Decomposition:
- Shared package / header (bus_defs):
  - state encoding localparams (IDLE=2'd0, WAIT=2'd1, SEND=2'd2, DONE=2'd3);
  - BUS_ADDR_WIDTH=12 and BUS_DATA_WIDTH=8, used by both master and slave ports.
- One sub-module is natural: piso_shift_reg, a parameterised load/shift-enable parallel-in-serial-out register.
  - Instantiate it twice: address lane and data lane.
  - The data lane is zero-padded to ADDR_WIDTH.
- The FSM and counter stay in master_out_port.

Test Plan:
- Reset: assert reset=0 mid-SEND (bit 5 of a frame) -> all outputs 0 immediately, state IDLE; no tx_done after release.
- Write frame: addr_in=12'hA5C, data_in=8'h3B, write_mode=1, slave_ready=1.
  - tx_addr sequence 0,0,1,1,1,0,1,0,0,1,0,1.
  - tx_data sequence 1,1,0,1,1,1,0,0,0,0,0,0.
  - master_valid high 13 cycles (WAIT + 12 SEND); tx_done pulses once at cycle 14 after start.
- Read frame: addr_in=12'h001, write_mode=0 -> tx_addr 1 then eleven 0s; tx_data 0 throughout; tx_done once.
- Stall: slave_ready low for 3 cycles at counter=4 of a write frame -> bit 4 held on both lanes for 4 cycles, master_valid stays 1, completion delayed by exactly 3 cycles. Slave ready low during WAIT for 5 cycles -> SEND starts on the first edge ready=1.
- Back-to-back / ignored start: pulse start during SEND and during DONE -> ignored (single tx_done). Hold start=1 continuously -> new frame accepted every 15 cycles, using the addr_in value present on each accepting edge.
